// File: rtl/change_dispenser.sv
// Greedy coin-change dispenser: ejects 5000/2000/1000/500 coins one at a time from a refillable stock.
// Optional macro CHANGE_ACK_TIMEOUT_EN adds a coin_ack timeout in EJECT.
module change_dispenser #(
  parameter int unsigned INIT_COUNT     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] change_amount,
  input  logic        refill,
  input  logic [1:0]  refill_coin,
  output logic        coin_valid,
  output logic [1:0]  coin_out,
  input  logic        coin_ack,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] remaining,
  output logic [3:0]  stock_500,
  output logic [3:0]  stock_1000,
  output logic [3:0]  stock_2000,
  output logic [3:0]  stock_5000
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SELECT = 2'd1;
  localparam logic [1:0] ST_EJECT  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  logic [1:0] state_r;
  logic [1:0] state_s;
  logic [3:0] stock_r [4];
  logic [1:0] pick_s;
  logic       pick_found_s;
  logic       ack_fire_s;
  logic       timeout_s;
  logic [3:0] refill_hit_s;
  logic [3:0] stock_dec_s;

  function automatic logic [15:0] coin_value(input logic [1:0] code);
    case (code)
      2'b00:   coin_value = 16'd500;
      2'b01:   coin_value = 16'd1000;
      2'b10:   coin_value = 16'd2000;
      default: coin_value = 16'd5000;
    endcase
  endfunction

  assign ack_fire_s   = coin_valid && coin_ack && (state_r == ST_EJECT);
  assign refill_hit_s = refill ? (4'b0001 << refill_coin) : 4'b0000;
  assign stock_dec_s  = ack_fire_s ? (4'b0001 << coin_out) : 4'b0000;

  assign stock_500  = stock_r[0];
  assign stock_1000 = stock_r[1];
  assign stock_2000 = stock_r[2];
  assign stock_5000 = stock_r[3];

  // Largest denomination that fits the remaining amount and is in stock
  always_comb begin
    pick_found_s = 1'b1;
    pick_s       = 2'b00;
    if (remaining >= 16'd5000 && stock_r[3] != 4'd0) begin
      pick_s = 2'b11;
    end else if (remaining >= 16'd2000 && stock_r[2] != 4'd0) begin
      pick_s = 2'b10;
    end else if (remaining >= 16'd1000 && stock_r[1] != 4'd0) begin
      pick_s = 2'b01;
    end else if (remaining >= 16'd500 && stock_r[0] != 4'd0) begin
      pick_s = 2'b00;
    end else begin
      pick_found_s = 1'b0;
    end
  end

`ifdef CHANGE_ACK_TIMEOUT_EN
  logic [7:0] tmo_cnt_r;

  // Cycles spent waiting for coin_ack in EJECT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_r <= 8'd0;
    end else if (state_r == ST_EJECT) begin
      tmo_cnt_r <= tmo_cnt_r + 8'd1;
    end else begin
      tmo_cnt_r <= 8'd0;
    end
  end

  assign timeout_s = (state_r == ST_EJECT) && !coin_ack &&
                     (tmo_cnt_r == 8'(TIMEOUT_CYCLES - 32'd1));
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_SELECT;
        else       state_s = ST_IDLE;
      end
      ST_SELECT: begin
        if (pick_found_s) state_s = ST_EJECT;
        else              state_s = ST_FINISH;
      end
      ST_EJECT: begin
        if (ack_fire_s)     state_s = ST_SELECT;
        else if (timeout_s) state_s = ST_FINISH;
        else                state_s = ST_EJECT;
      end
      ST_FINISH: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Control state and registered request outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      busy       <= 1'b0;
      coin_valid <= 1'b0;
      done       <= 1'b0;
      coin_out   <= 2'b00;
      remaining  <= 16'd0;
      error      <= 1'b0;
    end else begin
      state_r    <= state_s;
      busy       <= (state_s != ST_IDLE);
      coin_valid <= (state_s == ST_EJECT);
      done       <= (state_s == ST_FINISH);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            remaining <= change_amount;
            error     <= 1'b0;
          end
        end
        ST_SELECT: begin
          if (pick_found_s) coin_out <= pick_s;
          else if (remaining != 16'd0) error <= 1'b1;
        end
        ST_EJECT: begin
          if (ack_fire_s) remaining <= remaining - coin_value(coin_out);
          else if (timeout_s) error <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Stock counters; a refill and an eject on the same denomination cancel out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) stock_r[i] <= 4'(INIT_COUNT);
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (stock_dec_s[i] && !refill_hit_s[i]) begin
          stock_r[i] <= stock_r[i] - 4'd1;
        end else if (refill_hit_s[i] && !stock_dec_s[i] && stock_r[i] != 4'd15) begin
          stock_r[i] <= stock_r[i] + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with a greedy-change reference model and per-cycle stock checks.
module tb_change_dispenser;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] change_amount = 16'd0;
  logic        refill = 1'b0;
  logic [1:0]  refill_coin = 2'b00;
  logic        coin_ack = 1'b1;
  logic        coin_valid, busy, done, error;
  logic [1:0]  coin_out;
  logic [15:0] remaining;
  logic [3:0]  stock_500, stock_1000, stock_2000, stock_5000;

  change_dispenser dut (
    .clk(clk), .reset(reset), .start(start), .change_amount(change_amount),
    .refill(refill), .refill_coin(refill_coin), .coin_valid(coin_valid),
    .coin_out(coin_out), .coin_ack(coin_ack), .busy(busy), .done(done),
    .error(error), .remaining(remaining), .stock_500(stock_500),
    .stock_1000(stock_1000), .stock_2000(stock_2000), .stock_5000(stock_5000)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          m_stock [4];
  logic [1:0]  exp_q [$];
  logic [1:0]  obs_q [$];
  logic        exp_err;
  logic [15:0] exp_rem;
  bit          req_active = 1'b0;
  int          valid_cycles = 0;

  function automatic int val(input int code);
    case (code)
      0:       return 500;
      1:       return 1000;
      2:       return 2000;
      default: return 5000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected coin list: largest coin first while it fits and is in stock
  task automatic make_plan(input int amt);
    int s [4];
    int left;
    for (int d = 0; d < 4; d++) s[d] = m_stock[d];
    left = amt;
    exp_q.delete();
    for (int d = 3; d >= 0; d--) begin
      while (left >= val(d) && s[d] > 0) begin
        exp_q.push_back(2'(d));
        left -= val(d);
        s[d]--;
      end
    end
    exp_rem = 16'(left);
    exp_err = (left != 0);
  endtask

  // Reference model and per-cycle comparison
  always @(negedge clk) begin
    logic [1:0] e;
    if (reset) begin
      for (int d = 0; d < 4; d++) m_stock[d] = 10;
      exp_q.delete();
      req_active = 1'b0;
    end else begin
      check("stock_500", stock_500, m_stock[0]);
      check("stock_1000", stock_1000, m_stock[1]);
      check("stock_2000", stock_2000, m_stock[2]);
      check("stock_5000", stock_5000, m_stock[3]);
      if (coin_valid) begin
        check("valid_implies_busy", busy, 1);
        valid_cycles++;
      end
      if (coin_valid && coin_ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_coin_count", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("coin_out", coin_out, e);
        end
        obs_q.push_back(coin_out);
        if (!(refill && refill_coin == coin_out)) m_stock[coin_out]--;
      end
      if (refill && !(coin_valid && coin_ack && refill_coin == coin_out))
        if (m_stock[refill_coin] < 15) m_stock[refill_coin]++;
      if (done) begin
        check("done_expected", req_active, 1);
        check("done_error", error, exp_err);
        check("done_remaining", remaining, exp_rem);
        check("coins_left_over", exp_q.size(), 0);
        req_active = 1'b0;
      end
    end
  end

  task automatic wait_done(input int budget);
    int n = 0;
    while (req_active && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (req_active) begin
      check("done_timeout", 0, 1);
      req_active = 1'b0;
    end
  endtask

  // Launch a request; returns #1 after the edge that samples start
  task automatic launch(input int amt);
    make_plan(amt);
    obs_q.delete();
    req_active = 1'b1;
    start = 1'b1;
    change_amount = 16'(amt);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    check("rst_coin_valid", coin_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_remaining", remaining, 0);
    check("rst_stock_5000", stock_5000, 10);
    @(posedge clk); #1;

    // Zero amount: busy one cycle after sampling, done the cycle after
    launch(0);
    @(negedge clk);
    check("zero_busy", busy, 1);
    check("zero_done_early", done, 0);
    @(negedge clk);
    check("zero_done", done, 1);
    check("zero_error", error, 0);
    @(posedge clk); #1;

    launch(3500);
    @(negedge clk);
    check("first_busy", busy, 1);
    check("first_valid_early", coin_valid, 0);
    @(negedge clk);
    check("first_valid", coin_valid, 1);
    check("first_coin", coin_out, 2'b10);
    wait_done(20);
    check("b_ncoins", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      check("b_coin0", obs_q[0], 2'b10);
      check("b_coin1", obs_q[1], 2'b01);
      check("b_coin2", obs_q[2], 2'b00);
    end
    check("b_rem", remaining, 0);
    check("b_s2000", stock_2000, 9);
    check("b_s1000", stock_1000, 9);
    check("b_s500", stock_500, 9);

    do_reset();
    launch(12000);
    wait_done(20);
    check("l_ncoins", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      check("l_coin0", obs_q[0], 2'b11);
      check("l_coin1", obs_q[1], 2'b11);
      check("l_coin2", obs_q[2], 2'b10);
    end
    check("l_s5000", stock_5000, 8);
    check("l_s2000", stock_2000, 9);

    launch(700);
    wait_done(20);
    check("r_ncoins", obs_q.size(), 1);
    check("r_error", error, 1);
    check("r_rem", remaining, 200);

    do_reset();
    launch(50000);
    wait_done(40);
    check("x_ncoins", obs_q.size(), 10);
    check("x_s5000", stock_5000, 0);
    launch(5000);
    wait_done(20);
    check("x2_ncoins", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      check("x2_coin0", obs_q[0], 2'b10);
      check("x2_coin1", obs_q[1], 2'b10);
      check("x2_coin2", obs_q[2], 2'b01);
    end

    refill = 1'b1;
    refill_coin = 2'b00;
    repeat (6) @(posedge clk);
    #1 refill = 1'b0;
    @(negedge clk);
    check("sat_s500", stock_500, 15);
    @(posedge clk); #1;

    // Refill of 500 landing on the same edge as a 500-coin ack
    launch(500);
    @(posedge clk); #1;
    refill = 1'b1;
    refill_coin = 2'b00;
    @(posedge clk); #1;
    refill = 1'b0;
    wait_done(20);
    check("col_s500", stock_500, 15);

    // Ejector back-pressure: coin_valid and coin_out must hold
    coin_ack = 1'b0;
    launch(1000);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("bp_valid", coin_valid, 1);
    check("bp_coin", coin_out, 2'b01);
    @(posedge clk); #1;
    coin_ack = 1'b1;
    wait_done(20);
    check("bp_s1000", stock_1000, 8);

    // Asynchronous reset mid-request
    launch(2000);
    @(negedge clk);
    @(negedge clk);
    check("ar_valid_before", coin_valid, 1);
    coin_ack = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("ar_valid_drop", coin_valid, 0);
    check("ar_busy_drop", busy, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    coin_ack = 1'b1;
    @(negedge clk);
    check("ar_s2000", stock_2000, 10);
    @(posedge clk); #1;

`ifdef CHANGE_ACK_TIMEOUT_EN
    coin_ack = 1'b0;
    launch(1000);
    exp_q.delete();
    exp_err = 1'b1;
    exp_rem = 16'd1000;
    valid_cycles = 0;
    wait_done(400);
    check("t_valid_cycles", valid_cycles, 255);
    check("t_error", error, 1);
    check("t_rem", remaining, 1000);
    check("t_s1000", stock_1000, 10);
    coin_ack = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
